sprite_compositor: RTL and testbench

//   Parametrised pixel renderer between the object-position blocks (ball, paddles, ...) and vga.

---
 rtl/sprite_compositor_if.sv | 37 +++
 rtl/sprite_compositor.sv | 152 +++++++++++++++
 tb/tb_sprite_compositor.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_compositor_if.sv
// Bus between the vga timing / object-position blocks and the sprite compositor.
// master drives timing and sprite descriptors; slave (the compositor) returns
// the composited pixel and collision status.
interface sprite_compositor_if #(
  parameter int NUM_SPR = 3,
  parameter int CW      = 3,
  parameter int PW      = 11
);
  logic                    ptick;
  logic                    ftick;
  logic                    active;
  logic [9:0]              hpos;
  logic [9:0]              vpos;
  logic [NUM_SPR-1:0]      spr_en;
  logic [NUM_SPR*PW-1:0]   spr_x0;
  logic [NUM_SPR*PW-1:0]   spr_x1;
  logic [NUM_SPR*PW-1:0]   spr_y0;
  logic [NUM_SPR*PW-1:0]   spr_y1;
  logic [NUM_SPR*CW-1:0]   spr_color;
  logic [CW-1:0]           bg_color;
  logic [CW-1:0]           pixel;
  logic [3:0]              hit_id;
  logic [NUM_SPR-1:0]      coll_mask;
  logic                    coll_any;

  modport master (
    output ptick, ftick, active, hpos, vpos, spr_en, spr_x0, spr_x1,
           spr_y0, spr_y1, spr_color, bg_color,
    input  pixel, hit_id, coll_mask, coll_any
  );

  modport slave (
    input  ptick, ftick, active, hpos, vpos, spr_en, spr_x0, spr_x1,
           spr_y0, spr_y1, spr_color, bg_color,
    output pixel, hit_id, coll_mask, coll_any
  );
endinterface

// File: rtl/sprite_compositor.sv
// Sprite compositor: NUM_SPR inclusive-rectangle hit test, lowest-index
// priority, 2-stage ptick pipeline to the vga pixel, and a per-frame
// sprite-overlap report (coll_mask/coll_any) published on ftick.
// Optional feature macro: SPR_SHADOW_EN -- sprite descriptors are latched on
// ftick so mid-frame updates cannot tear the picture.
module sprite_compositor #(
  parameter int NUM_SPR = 3,
  parameter int CW      = 3,
  parameter int PW      = 11
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sprite_compositor_if.slave  bus
);

  logic [NUM_SPR-1:0]    cur_en;
  logic [NUM_SPR*PW-1:0] cur_x0, cur_x1, cur_y0, cur_y1;
  logic [NUM_SPR*CW-1:0] cur_col;

`ifdef SPR_SHADOW_EN
  logic [NUM_SPR-1:0]    en_q;
  logic [NUM_SPR*PW-1:0] x0_q, x1_q, y0_q, y1_q;
  logic [NUM_SPR*CW-1:0] col_q;

  // Latch sprite descriptors once per frame, at entry to blanking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q  <= '0;
      x0_q  <= '0;
      x1_q  <= '0;
      y0_q  <= '0;
      y1_q  <= '0;
      col_q <= '0;
    end else if (bus.ftick) begin
      en_q  <= bus.spr_en;
      x0_q  <= bus.spr_x0;
      x1_q  <= bus.spr_x1;
      y0_q  <= bus.spr_y0;
      y1_q  <= bus.spr_y1;
      col_q <= bus.spr_color;
    end
  end

  assign cur_en  = en_q;
  assign cur_x0  = x0_q;
  assign cur_x1  = x1_q;
  assign cur_y0  = y0_q;
  assign cur_y1  = y1_q;
  assign cur_col = col_q;
`else
  assign cur_en  = bus.spr_en;
  assign cur_x0  = bus.spr_x0;
  assign cur_x1  = bus.spr_x1;
  assign cur_y0  = bus.spr_y0;
  assign cur_y1  = bus.spr_y1;
  assign cur_col = bus.spr_color;
`endif

  // Screen position as a non-negative signed value one bit wider than the
  // bounds, so negative (off-screen) bounds compare correctly.
  logic signed [PW:0] h_s, v_s;
  assign h_s = {{(PW+1-10){1'b0}}, bus.hpos};
  assign v_s = {{(PW+1-10){1'b0}}, bus.vpos};

  logic [NUM_SPR-1:0] hit_d;

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_cmp
    logic signed [PW:0] x0, x1, y0, y1;
    assign x0 = {cur_x0[i*PW+PW-1], cur_x0[i*PW +: PW]};
    assign x1 = {cur_x1[i*PW+PW-1], cur_x1[i*PW +: PW]};
    assign y0 = {cur_y0[i*PW+PW-1], cur_y0[i*PW +: PW]};
    assign y1 = {cur_y1[i*PW+PW-1], cur_y1[i*PW +: PW]};
    // An inverted rectangle (x0>x1 or y0>y1) can never satisfy both bounds.
    assign hit_d[i] = cur_en[i] && (h_s >= x0) && (h_s <= x1) &&
                      (v_s >= y0) && (v_s <= y1);
  end

  logic [NUM_SPR-1:0] hit_s1_q;
  logic               act_s1_q;

  // Stage 1: register hit vector and visible-area flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_s1_q <= '0;
      act_s1_q <= 1'b0;
    end else if (bus.ptick) begin
      hit_s1_q <= hit_d;
      act_s1_q <= bus.active;
    end
  end

  logic [CW-1:0] pix_d, pix_q;
  logic [3:0]    id_d, id_q;

  // Priority resolve: blank outside the visible area, lowest index wins.
  always_comb begin
    pix_d = '0;
    id_d  = 4'hF;
    if (act_s1_q) begin
      pix_d = bus.bg_color;
      for (int i = NUM_SPR-1; i >= 0; i--) begin
        if (hit_s1_q[i]) begin
          pix_d = cur_col[i*CW +: CW];
          id_d  = 4'(i);
        end
      end
    end
  end

  // Stage 2: composited pixel and winning sprite index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_q <= '0;
      id_q  <= 4'hF;
    end else if (bus.ptick) begin
      pix_q <= pix_d;
      id_q  <= id_d;
    end
  end

  // Two or more bits set iff clearing the lowest set bit leaves something.
  logic               multi;
  logic [NUM_SPR-1:0] contrib_d, acc_q, acc_d, mask_d, mask_q;
  logic               any_q;

  assign multi     = |(hit_s1_q & (hit_s1_q - NUM_SPR'(1)));
  assign contrib_d = (bus.ptick && act_s1_q && multi) ? hit_s1_q : '0;
  assign mask_d    = acc_q | contrib_d;
  assign acc_d     = bus.ftick ? '0 : mask_d;

  // Overlap accumulator; on ftick publish it (including this cycle's
  // contribution) and start a fresh frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      mask_q <= '0;
      any_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (bus.ftick) begin
        mask_q <= mask_d;
        any_q  <= |mask_d;
      end
    end
  end

  assign bus.pixel     = pix_q;
  assign bus.hit_id    = id_q;
  assign bus.coll_mask = mask_q;
  assign bus.coll_any  = any_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor (NUM_SPR=3, CW=3, PW=11).
module tb_sprite_compositor;
  localparam int NS = 3;
  localparam int CW = 3;
  localparam int PW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sprite_compositor_if #(.NUM_SPR(NS), .CW(CW), .PW(PW)) bus ();

  sprite_compositor #(.NUM_SPR(NS), .CW(CW), .PW(PW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_spr(input int i, input int x0, input int x1, input int y0,
                         input int y1, input logic [CW-1:0] c, input logic en);
    bus.spr_x0[i*PW +: PW]    = PW'(x0);
    bus.spr_x1[i*PW +: PW]    = PW'(x1);
    bus.spr_y0[i*PW +: PW]    = PW'(y0);
    bus.spr_y1[i*PW +: PW]    = PW'(y1);
    bus.spr_color[i*CW +: CW] = c;
    bus.spr_en[i]             = en;
  endtask

  // One ftick cycle without ptick: loads shadows (if present), publishes acc.
  task automatic apply();
    bus.ftick = 1'b1;
    step();
    bus.ftick = 1'b0;
  endtask

  // Present a pixel and give it the two ptick pulses it needs to reach pixel.
  task automatic pix(input int h, input int v, input logic a);
    bus.hpos   = 10'(h);
    bus.vpos   = 10'(v);
    bus.active = a;
    bus.ptick  = 1'b1;
    step();
    step();
    bus.ptick  = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (bus.pixel !== 3'd0) begin n_fail++; $display("FAIL reset_pixel got %0d exp 0", bus.pixel); end
    n_chk++; if (bus.hit_id !== 4'hF) begin n_fail++; $display("FAIL reset_hit_id got %h exp F", bus.hit_id); end
    n_chk++; if (bus.coll_mask !== 3'b000) begin n_fail++; $display("FAIL reset_coll_mask got %b exp 000", bus.coll_mask); end
    n_chk++; if (bus.coll_any !== 1'b0) begin n_fail++; $display("FAIL reset_coll_any got %b exp 0", bus.coll_any); end
  endtask

  task automatic test_basic();
    set_spr(0, 10, 14, 20, 24, 3'b111, 1'b1);
    set_spr(1, 0, 0, 0, 0, 3'b000, 1'b0);
    set_spr(2, 0, 0, 0, 0, 3'b000, 1'b0);
    bus.bg_color = 3'd0;
    apply();
    pix(12, 22, 1'b1);
    n_chk++; if (bus.pixel !== 3'd7) begin n_fail++; $display("FAIL basic_hit_pixel got %0d exp 7", bus.pixel); end
    n_chk++; if (bus.hit_id !== 4'h0) begin n_fail++; $display("FAIL basic_hit_id got %h exp 0", bus.hit_id); end
    pix(15, 22, 1'b1);
    n_chk++; if (bus.pixel !== 3'd0) begin n_fail++; $display("FAIL basic_miss_pixel got %0d exp 0", bus.pixel); end
    n_chk++; if (bus.hit_id !== 4'hF) begin n_fail++; $display("FAIL basic_miss_id got %h exp F", bus.hit_id); end
    bus.bg_color = 3'd5;
    pix(14, 24, 1'b1);
    n_chk++; if (bus.pixel !== 3'd7) begin n_fail++; $display("FAIL basic_corner_pixel got %0d exp 7", bus.pixel); end
    pix(14, 25, 1'b1);
    n_chk++; if (bus.pixel !== 3'd5) begin n_fail++; $display("FAIL basic_bg_pixel got %0d exp 5", bus.pixel); end
    n_chk++; if (bus.hit_id !== 4'hF) begin n_fail++; $display("FAIL basic_bg_id got %h exp F", bus.hit_id); end
    pix(10, 20, 1'b1);
    n_chk++; if (bus.hit_id !== 4'h0) begin n_fail++; $display("FAIL basic_origin_id got %h exp 0", bus.hit_id); end
    bus.bg_color = 3'd0;
  endtask

  task automatic test_priority();
    set_spr(0, 90, 110, 90, 110, 3'b001, 1'b1);
    set_spr(1, 95, 105, 95, 105, 3'b010, 1'b1);
    apply();
    pix(100, 100, 1'b1);
    n_chk++; if (bus.pixel !== 3'b001) begin n_fail++; $display("FAIL prio_pixel got %b exp 001", bus.pixel); end
    n_chk++; if (bus.hit_id !== 4'h0) begin n_fail++; $display("FAIL prio_id got %h exp 0", bus.hit_id); end
    bus.spr_en[0] = 1'b0;
    apply();
    pix(100, 100, 1'b1);
    n_chk++; if (bus.pixel !== 3'b010) begin n_fail++; $display("FAIL prio_dis_pixel got %b exp 010", bus.pixel); end
    n_chk++; if (bus.hit_id !== 4'h1) begin n_fail++; $display("FAIL prio_dis_id got %h exp 1", bus.hit_id); end
    bus.spr_en[0] = 1'b1;
    apply();
  endtask

  task automatic test_collision();
    apply();
    pix(100, 100, 1'b1);
    pix(0, 0, 1'b1);
    apply();
    n_chk++; if (bus.coll_mask !== 3'b011) begin n_fail++; $display("FAIL coll_mask got %b exp 011", bus.coll_mask); end
    n_chk++; if (bus.coll_any !== 1'b1) begin n_fail++; $display("FAIL coll_any got %b exp 1", bus.coll_any); end
    pix(0, 0, 1'b1);
    apply();
    n_chk++; if (bus.coll_mask !== 3'b000) begin n_fail++; $display("FAIL coll_clear_mask got %b exp 000", bus.coll_mask); end
    n_chk++; if (bus.coll_any !== 1'b0) begin n_fail++; $display("FAIL coll_clear_any got %b exp 0", bus.coll_any); end
    // overlap reaches stage 1 and is accumulated on the very ftick cycle
    bus.hpos = 10'd100; bus.vpos = 10'd100; bus.active = 1'b1;
    bus.ptick = 1'b1;
    step();
    bus.ftick = 1'b1;
    step();
    bus.ftick = 1'b0;
    bus.ptick = 1'b0;
    n_chk++; if (bus.coll_mask !== 3'b011) begin n_fail++; $display("FAIL coll_same_cycle got %b exp 011", bus.coll_mask); end
    n_chk++; if (bus.coll_any !== 1'b1) begin n_fail++; $display("FAIL coll_same_any got %b exp 1", bus.coll_any); end
  endtask

  task automatic test_rst_mid();
    bus.ptick = 1'b1;
    step();
    bus.ptick = 1'b0;
    n_chk++; if (bus.pixel !== 3'b001) begin n_fail++; $display("FAIL pre_rst_pixel got %b exp 001", bus.pixel); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if (bus.pixel !== 3'd0) begin n_fail++; $display("FAIL rst_mid_pixel got %0d exp 0", bus.pixel); end
    n_chk++; if (bus.hit_id !== 4'hF) begin n_fail++; $display("FAIL rst_mid_id got %h exp F", bus.hit_id); end
    n_chk++; if (bus.coll_mask !== 3'b000) begin n_fail++; $display("FAIL rst_mid_mask got %b exp 000", bus.coll_mask); end
    n_chk++; if (bus.coll_any !== 1'b0) begin n_fail++; $display("FAIL rst_mid_any got %b exp 0", bus.coll_any); end
  endtask

  task automatic test_active();
    set_spr(0, 10, 14, 20, 24, 3'b111, 1'b1);
    set_spr(1, 0, 0, 0, 0, 3'b000, 1'b0);
    apply();
    pix(12, 22, 1'b0);
    n_chk++; if (bus.pixel !== 3'd0) begin n_fail++; $display("FAIL inactive_pixel got %0d exp 0", bus.pixel); end
    n_chk++; if (bus.hit_id !== 4'hF) begin n_fail++; $display("FAIL inactive_id got %h exp F", bus.hit_id); end
    pix(12, 22, 1'b1);
    bus.hpos = 10'd300;
    for (int k = 0; k < 5; k++) step();
    n_chk++; if (bus.pixel !== 3'd7) begin n_fail++; $display("FAIL hold_pixel got %0d exp 7", bus.pixel); end
    n_chk++; if (bus.hit_id !== 4'h0) begin n_fail++; $display("FAIL hold_id got %h exp 0", bus.hit_id); end
  endtask

  task automatic test_negative();
    set_spr(0, -3, 2, 20, 24, 3'b111, 1'b1);
    apply();
    pix(0, 22, 1'b1);
    n_chk++; if (bus.hit_id !== 4'h0) begin n_fail++; $display("FAIL neg_h0 got %h exp 0", bus.hit_id); end
    pix(2, 22, 1'b1);
    n_chk++; if (bus.hit_id !== 4'h0) begin n_fail++; $display("FAIL neg_h2 got %h exp 0", bus.hit_id); end
    pix(3, 22, 1'b1);
    n_chk++; if (bus.hit_id !== 4'hF) begin n_fail++; $display("FAIL neg_h3 got %h exp F", bus.hit_id); end
    set_spr(0, 20, 10, 20, 24, 3'b111, 1'b1);
    apply();
    pix(15, 22, 1'b1);
    n_chk++; if (bus.hit_id !== 4'hF) begin n_fail++; $display("FAIL inv_h15 got %h exp F", bus.hit_id); end
    pix(10, 22, 1'b1);
    n_chk++; if (bus.hit_id !== 4'hF) begin n_fail++; $display("FAIL inv_h10 got %h exp F", bus.hit_id); end
  endtask

  task automatic test_shadow();
    set_spr(0, 10, 14, 20, 24, 3'b111, 1'b1);
    apply();
    pix(12, 22, 1'b1);
    n_chk++; if (bus.pixel !== 3'd7) begin n_fail++; $display("FAIL mv_old_pre got %0d exp 7", bus.pixel); end
    set_spr(0, 50, 54, 20, 24, 3'b111, 1'b1);
`ifdef SPR_SHADOW_EN
    pix(12, 22, 1'b1);
    n_chk++; if (bus.hit_id !== 4'h0) begin n_fail++; $display("FAIL mv_old_mid got %h exp 0", bus.hit_id); end
    pix(52, 22, 1'b1);
    n_chk++; if (bus.hit_id !== 4'hF) begin n_fail++; $display("FAIL mv_new_mid got %h exp F", bus.hit_id); end
`else
    pix(12, 22, 1'b1);
    n_chk++; if (bus.hit_id !== 4'hF) begin n_fail++; $display("FAIL mv_old_mid got %h exp F", bus.hit_id); end
    pix(52, 22, 1'b1);
    n_chk++; if (bus.hit_id !== 4'h0) begin n_fail++; $display("FAIL mv_new_mid got %h exp 0", bus.hit_id); end
`endif
    apply();
    pix(52, 22, 1'b1);
    n_chk++; if (bus.hit_id !== 4'h0) begin n_fail++; $display("FAIL mv_new_post got %h exp 0", bus.hit_id); end
    pix(12, 22, 1'b1);
    n_chk++; if (bus.hit_id !== 4'hF) begin n_fail++; $display("FAIL mv_old_post got %h exp F", bus.hit_id); end
  endtask

  initial begin
    bus.ptick = 1'b0; bus.ftick = 1'b0; bus.active = 1'b0;
    bus.hpos = '0; bus.vpos = '0; bus.spr_en = '0;
    bus.spr_x0 = '0; bus.spr_x1 = '0; bus.spr_y0 = '0; bus.spr_y1 = '0;
    bus.spr_color = '0; bus.bg_color = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_collision();
    test_rst_mid();
    test_active();
    test_negative();
    test_shadow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
